// File: rtl/i2c_master_write_if.sv
// Host-side handshake for the I2C write master: request, latched operands and status.
interface i2c_master_write_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (output start, addr, data_in, input busy, done, ack_err);
  modport slave  (input start, addr, data_in, output busy, done, ack_err);
endinterface

// File: rtl/i2c_master_write.sv
// Single-byte I2C write master: START, 7-bit address + W, ACK, data byte, ACK, STOP.
// Every bus phase is four SCL quarters of QDIV clk cycles each.
module i2c_master_write #(
  parameter int QDIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_master_write_if.slave    bus,
  output logic                 SCL,
  inout  wire                  SDA,
  output logic [2:0]           o_dbg_state
);

  localparam int CW = (QDIV <= 2) ? 1 : $clog2(QDIV);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK1  = 3'd3,
    DATA  = 3'd4,
    ACK2  = 3'd5,
    STOP  = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_q;
  logic [3:0]    r_bit;
  logic [6:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_nack;
  logic          r_done;
  logic          r_ack_err;

  logic          w_accept;
  logic          w_tick;
  logic          w_qend;
  logic          w_sample;
  logic          w_bitval;
  logic          w_sda_low;
  logic [7:0]    w_addr_byte;

  // No acceptance in the done cycle, so a start coincident with busy falling is dropped.
  assign w_accept    = (r_state == IDLE) && bus.start && !r_done;
  assign w_tick      = (r_state != IDLE) && (r_cnt == CW'(QDIV - 1));
  assign w_qend      = w_tick && (r_q == 2'd3);
  assign w_sample    = w_tick && (r_q == 2'd1);
  assign w_addr_byte = {r_addr, 1'b0};
  assign w_bitval    = (r_state == DATA) ? r_data[r_bit[2:0]] : w_addr_byte[r_bit[2:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = START;
      START: if (w_qend) w_state_nxt = ADDR;
      ADDR:  if (w_qend && r_bit == 4'd0) w_state_nxt = ACK1;
      ACK1:  if (w_qend) w_state_nxt = r_nack ? STOP : DATA;
      DATA:  if (w_qend && r_bit == 4'd0) w_state_nxt = ACK2;
      ACK2:  if (w_qend) w_state_nxt = STOP;
      STOP:  if (w_qend) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_q       <= 2'd0;
      r_bit     <= 4'd0;
      r_addr    <= 7'd0;
      r_data    <= 8'd0;
      r_nack    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_addr    <= bus.addr;
        r_data    <= bus.data_in;
        r_ack_err <= 1'b0;
        r_nack    <= 1'b0;
        r_cnt     <= '0;
        r_q       <= 2'd0;
        r_bit     <= 4'd0;
      end else if (r_state != IDLE) begin
        if (w_tick) begin
          r_cnt <= '0;
          r_q   <= r_q + 2'd1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_sample && (r_state == ACK1 || r_state == ACK2))
          r_nack <= SDA;
        if (w_qend) begin
          case (r_state)
            START: r_bit <= 4'd7;
            ADDR, DATA: if (r_bit != 4'd0) r_bit <= r_bit - 4'd1;
            ACK1: begin
              if (r_nack) r_ack_err <= 1'b1;
              else        r_bit     <= 4'd7;
            end
            ACK2: if (r_nack) r_ack_err <= 1'b1;
            STOP: r_done <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Bus pins decode straight from registered state so reset releases them without a clock.
  always_comb begin
    SCL       = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      START: w_sda_low = (r_q >= 2'd2);
      ADDR, DATA: begin
        SCL       = (r_q == 2'd1) || (r_q == 2'd2);
        w_sda_low = !w_bitval;
      end
      ACK1, ACK2: SCL = (r_q == 2'd1) || (r_q == 2'd2);
      STOP: begin
        SCL       = (r_q != 2'd0);
        w_sda_low = (r_q <= 2'd1);
      end
      default: ;
    endcase
  end

  assign SDA         = w_sda_low ? 1'b0 : 1'bz;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.ack_err = r_ack_err;
  assign o_dbg_state = r_state;

endmodule

// File: doc/i2c_master_write.md
I2C_MASTER_WRITE -- requirements
Module: i2c_master_write

Interface
REQ-001 SHALL have parameter QDIV, default 4: clk cycles per SCL quarter-period; legal values >= 2.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one write transaction; sampled only while idle.
REQ-005 SHALL have port addr  input  7  target 7-bit slave address, MSB first on bus.
REQ-006 SHALL have port data_in  input  8  byte to write, MSB first on bus.
REQ-007 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-009 SHALL have port ack_err  output  1  slave NACKed the last transaction; sticky until the next accepted start.
REQ-010 SHALL have port SCL  output  1  I2C clock, driven push-pull.
REQ-011 SHALL have port SDA  inout  1  I2C data, open-drain: drives 0 or high-Z only; never drives 1.

Function
REQ-012 SHALL use states IDLE, START, ADDR, ACK1, DATA, ACK2, STOP.
REQ-013 SHALL accept a start when start=1 in IDLE: latch addr, data_in and R/W=0; busy=1 and state=START from the next edge; ack_err cleared on the same edge.
REQ-014 SHALL ignore start while busy=1; latched addr/data SHALL not change mid-transaction.
REQ-015 SHALL run the quarter divider only outside IDLE: counter 0..QDIV-1, cleared on acceptance; tick when counter=QDIV-1; quarter index q 0..3 advances on each tick.
REQ-016 In IDLE: SCL=1, SDA released.
REQ-017 START (4 quarters): q0-q1 SCL=1 SDA released; q2-q3 SCL=1 SDA=0; then go to ADDR.
REQ-018 Each data bit (4 quarters): q0 SCL=0 with SDA set to the bit value (0 -> drive low, 1 -> release); q1-q2 SCL=1; q3 SCL=0. SDA SHALL be stable for all 4 quarters.
REQ-019 ADDR SHALL send 8 bits, addr[6] down to addr[0], then R/W=0; DATA SHALL send data_in[7] down to [0].
REQ-020 ACK1/ACK2: SDA released for 4 quarters, SCL pattern as REQ-018; SDA sampled on the tick ending q1.
REQ-021 Sample 0 (ACK): ACK1 -> DATA, ACK2 -> STOP. Sample 1 (NACK): ack_err=1, go directly to STOP; DATA is skipped after a NACK in ACK1.
REQ-022 STOP (4 quarters): q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2-q3 SCL=1 SDA released.
REQ-023 On the final STOP tick: state=IDLE, busy=0 and done=1 on the same edge; done=0 on the following edge.
REQ-024 ACKed transaction SHALL last exactly 80 quarters: busy high for 80*QDIV clk cycles. ACK1 NACK transaction SHALL last 44 quarters.
REQ-025 A start asserted in the same cycle busy falls SHALL be ignored; start is accepted from the next cycle.
REQ-026 Bit counter SHALL count 7 down to 0 per byte; 4 bits wide, no wrap past 0.

Reset
REQ-027 reset=1 SHALL immediately, without a clock, force: state=IDLE, busy=0, done=0, ack_err=0, SCL=1, SDA released, divider and bit counters=0.
REQ-028 Reset asserted mid-transaction SHALL abort without issuing STOP; first start after release SHALL begin a full new frame.

Verification
REQ-029 QDIV=4, addr=7'h4F, data_in=8'hA5, slave ACKs both -> SDA bits 1001111 0, ACK, 10100101, ACK, STOP; busy high 320 cycles; one done pulse; ack_err=0.
REQ-030 Address byte NACKed (SDA pulled up at ACK1) -> ack_err=1, no DATA bits, STOP follows; busy high 176 cycles.
REQ-031 Data byte NACKed at ACK2 -> ack_err=1 after STOP; next accepted start clears ack_err.
REQ-032 start pulsed again while busy, and in the cycle done=1 -> no second frame; start one cycle later -> new frame begins.
REQ-033 reset asserted at bit 3 of DATA -> SCL=1, SDA=Z, busy=0 within the same cycle, no clock needed; a subsequent start gives a complete 80-quarter frame.
REQ-034 Checker: SDA changes only while SCL=0, except the START and STOP edges; SDA is never driven 1.
